// File: rtl/nq_bus_pkg.sv
// Shared types for the external memory bus arbiter.
//   arb_state_e : arbiter FSM states
//   bus_req_t   : one master's request bundle {addr, re, we, lock, wdata}
//   ADDR_W_DEF / DATA_W_DEF : default bus widths
package nq_bus_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_M0   = 2'd1,
    ARB_M1   = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic                  re;
    logic                  we;
    logic                  lock;
    logic [DATA_W_DEF-1:0] wdata;
  } bus_req_t;

  function automatic logic req_active(input bus_req_t r);
    return r.re | r.we;
  endfunction

endpackage

// File: rtl/arb_hold_counter.sv
// Saturating up-counter measuring how long the current master has held the bus.
//   clk, rst_n  : clock, async active-low reset
//   i_clr       : synchronous clear (wins over enable)
//   i_en        : count one granted cycle
//   o_at_limit  : count has reached MAX_HOLD (stays there until cleared)
module arb_hold_counter #(
  parameter int MAX_HOLD = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_at_limit
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_limit;

  assign w_at_limit = (r_cnt >= CNT_W'(MAX_HOLD));
  assign o_at_limit = w_at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_limit) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ext_bus_arbiter.sv
// Two-master round-robin arbiter in front of the external memory interface.
// Master 0 is the CPU, master 1 a secondary bus master. A lock keeps the grant
// across transfers; the hold counter forces a locked master to yield to a
// waiting peer once it has held the bus MAX_HOLD cycles, but only between
// transfers.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   mK_addr_i/re_i/we_i/lock_i/wdata_i   master K request
//   mK_rdata_o, mK_needWait_o        master K response (0 / 1 when not granted)
//   bus_addr_o/re_o/we_o/wdata_o     to memory interface
//   bus_rdata_i, bus_needWait_i      from memory interface
//   grant_o                          one-hot grant {M1, M0}, 00 when idle
//
// state    | meaning
// ARB_IDLE | no grant; bus strobes 0; picks next master (one-cycle bubble)
// ARB_M0   | master 0 owns the bus
// ARB_M1   | master 1 owns the bus
module ext_bus_arbiter
  import nq_bus_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic              m0_re_i,
  input  logic              m0_we_i,
  input  logic              m0_lock_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_needWait_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic              m1_re_i,
  input  logic              m1_we_i,
  input  logic              m1_lock_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_needWait_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic              bus_re_o,
  output logic              bus_we_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_needWait_i,
  output logic [1:0]        grant_o
);

  arb_state_e r_state, w_state_nxt;
  logic       r_last_grant, w_last_grant_nxt;

  bus_req_t w_m0, w_m1, w_sel;
  logic     w_req0, w_req1;
  logic     w_sel_req, w_other_req;
  logic     w_in_flight, w_done, w_release;
  logic     w_hold_clr, w_at_limit;

  assign w_m0 = '{addr: ADDR_W_DEF'(m0_addr_i), re: m0_re_i, we: m0_we_i,
                  lock: m0_lock_i, wdata: DATA_W_DEF'(m0_wdata_i)};
  assign w_m1 = '{addr: ADDR_W_DEF'(m1_addr_i), re: m1_re_i, we: m1_we_i,
                  lock: m1_lock_i, wdata: DATA_W_DEF'(m1_wdata_i)};

  assign w_req0 = req_active(w_m0);
  assign w_req1 = req_active(w_m1);

  // w_sel is all-zero in IDLE, which also zeroes the bus outputs there.
  always_comb begin
    w_sel       = '0;
    w_other_req = 1'b0;
    case (r_state)
      ARB_M0: begin
        w_sel       = w_m0;
        w_other_req = w_req1;
      end
      ARB_M1: begin
        w_sel       = w_m1;
        w_other_req = w_req0;
      end
      default: ;
    endcase
  end

  assign w_sel_req   = req_active(w_sel);
  assign w_in_flight = w_sel_req & bus_needWait_i;
  assign w_done      = w_sel_req & ~bus_needWait_i;

  // Hold-limit release only between transfers so address/strobes never
  // change under a stalled access.
  assign w_release = (w_done & ~w_sel.lock)
                   | (~w_sel_req & ~w_sel.lock)
                   | (w_at_limit & w_other_req & ~w_in_flight);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= 1'b1;  // M0 wins the first tie
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_hold_clr       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        // On a tie the master that did not win last time is chosen.
        if (w_req0 && (!w_req1 || r_last_grant)) begin
          w_state_nxt      = ARB_M0;
          w_last_grant_nxt = 1'b0;
          w_hold_clr       = 1'b1;
        end else if (w_req1) begin
          w_state_nxt      = ARB_M1;
          w_last_grant_nxt = 1'b1;
          w_hold_clr       = 1'b1;
        end
      end
      ARB_M0, ARB_M1: begin
        if (w_release) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  arb_hold_counter #(
    .MAX_HOLD(MAX_HOLD)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_hold_clr),
    .i_en      (r_state != ARB_IDLE),
    .o_at_limit(w_at_limit)
  );

  assign bus_addr_o  = ADDR_W'(w_sel.addr);
  assign bus_re_o    = w_sel.re;
  assign bus_we_o    = w_sel.we;
  assign bus_wdata_o = DATA_W'(w_sel.wdata);

  assign grant_o = {r_state == ARB_M1, r_state == ARB_M0};

  // Ungranted master sees a permanent wait, so it simply holds its strobes.
  assign m0_needWait_o = (r_state == ARB_M0) ? bus_needWait_i : 1'b1;
  assign m1_needWait_o = (r_state == ARB_M1) ? bus_needWait_i : 1'b1;
  assign m0_rdata_o    = (r_state == ARB_M0) ? bus_rdata_i : '0;
  assign m1_rdata_o    = (r_state == ARB_M1) ? bus_rdata_i : '0;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Directed bench for ext_bus_arbiter with a scoreboard. Each stimulus cycle
// pushes the hand-derived grant for that cycle plus the expected bus/master
// outputs; a monitor on the falling edge pops and compares.
module tb_ext_bus_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_re, m0_we, m0_lock, m1_re, m1_we, m1_lock;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_nw, m1_nw;
  logic [AW-1:0] bus_addr;
  logic          bus_re, bus_we;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_nw;
  logic [1:0]    grant;

  always #5 clk = ~clk;

  ext_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr_i(m0_addr), .m0_re_i(m0_re), .m0_we_i(m0_we), .m0_lock_i(m0_lock),
    .m0_wdata_i(m0_wdata), .m0_rdata_o(m0_rdata), .m0_needWait_o(m0_nw),
    .m1_addr_i(m1_addr), .m1_re_i(m1_re), .m1_we_i(m1_we), .m1_lock_i(m1_lock),
    .m1_wdata_i(m1_wdata), .m1_rdata_o(m1_rdata), .m1_needWait_o(m1_nw),
    .bus_addr_o(bus_addr), .bus_re_o(bus_re), .bus_we_o(bus_we),
    .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata), .bus_needWait_i(bus_nw),
    .grant_o(grant)
  );

  typedef struct packed {
    logic [1:0]    g;
    logic          re;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          nw0;
    logic          nw1;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  obs_t  mon_e, mon_a;
  string mon_n;

  // Expected outputs given the hand-computed grant for this cycle.
  function automatic obs_t model(input logic [1:0] g);
    obs_t o;
    o = '0;
    o.g   = g;
    o.nw0 = 1'b1;
    o.nw1 = 1'b1;
    if (g == 2'b01) begin
      o.re = m0_re; o.we = m0_we; o.addr = m0_addr; o.wd = m0_wdata;
      o.nw0 = bus_nw; o.rd0 = bus_rdata;
    end else if (g == 2'b10) begin
      o.re = m1_re; o.we = m1_we; o.addr = m1_addr; o.wd = m1_wdata;
      o.nw1 = bus_nw; o.rd1 = bus_rdata;
    end
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.g = grant; o.re = bus_re; o.we = bus_we; o.addr = bus_addr; o.wd = bus_wdata;
    o.nw0 = m0_nw; o.nw1 = m1_nw; o.rd0 = m0_rdata; o.rd1 = m1_rdata;
    return o;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      mon_a = sample();
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", mon_n, mon_a, mon_e);
      end
    end
  end

  task automatic step(input string nm, input logic [1:0] g);
    exp_q.push_back(model(g));
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic re, input logic we, input logic lk,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    m0_re = re; m0_we = we; m0_lock = lk; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic re, input logic we, input logic lk,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    m1_re = re; m1_we = we; m1_lock = lk; m1_addr = a; m1_wdata = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_m0(0, 0, 0, '0, '0);
    set_m1(0, 0, 0, '0, '0);
    bus_nw = 1'b0;
    bus_rdata = 16'h0000;
    step("reset", 2'b00);
    step("reset", 2'b00);
    rst_n = 1'b1;
  endtask

  initial begin
    set_m0(0, 0, 0, '0, '0);
    set_m1(0, 0, 0, '0, '0);
    bus_nw = 1'b0;
    bus_rdata = 16'h0000;
    @(posedge clk);
    #1;

    // Simultaneous requests from reset release: M0, M1, M0, M1 with bubbles.
    do_reset();
    set_m0(1, 0, 0, 24'h000010, 16'h0000);
    set_m1(0, 1, 0, 24'h000020, 16'h5555);
    bus_rdata = 16'h1357;
    step("sim_c0", 2'b00);
    step("sim_c1", 2'b01);
    step("sim_c2", 2'b00);
    step("sim_c3", 2'b10);
    step("sim_c4", 2'b00);
    step("sim_c5", 2'b01);
    step("sim_c6", 2'b00);
    step("sim_c7", 2'b10);
    set_m0(0, 0, 0, '0, '0);
    set_m1(0, 0, 0, '0, '0);
    step("sim_end", 2'b00);

    // Single master read, three wait cycles.
    do_reset();
    bus_rdata = 16'hBEEF;
    set_m0(1, 0, 0, 24'h000100, 16'h0000);
    bus_nw = 1'b1;
    step("single_c0", 2'b00);
    step("single_c1", 2'b01);
    step("single_c2", 2'b01);
    step("single_c3", 2'b01);
    bus_nw = 1'b0;
    step("single_c4", 2'b01);
    set_m0(0, 0, 0, 24'h000100, 16'h0000);
    step("single_c5", 2'b00);

    // Locked write burst from M1, then lock with no request, then unlock.
    do_reset();
    set_m1(0, 1, 1, 24'h200000, 16'hA5A5);
    step("lock_c0", 2'b00);
    step("lock_w0", 2'b10);
    m1_addr = 24'h200002;
    step("lock_w1", 2'b10);
    m1_addr = 24'h200004;
    step("lock_w2", 2'b10);
    m1_addr = 24'h200006;
    step("lock_w3", 2'b10);
    set_m1(0, 0, 1, 24'h200006, 16'hA5A5);
    step("lock_hold", 2'b10);
    set_m1(0, 0, 0, 24'h200006, 16'hA5A5);
    step("lock_unlock", 2'b10);
    step("lock_idle", 2'b00);

    // Starvation: M1 locked streaming, M0 waiting from cycle 2. At the limit a
    // stalled M1 access is not preempted; release follows its completion.
    do_reset();
    set_m1(0, 1, 1, 24'h300000, 16'h0F0F);
    bus_rdata = 16'h2468;
    step("starv_c0", 2'b00);
    step("starv_c1", 2'b10);
    set_m0(1, 0, 0, 24'h000400, 16'h0000);
    step("starv_c2", 2'b10);
    step("starv_c3", 2'b10);
    step("starv_c4", 2'b10);
    bus_nw = 1'b1;
    step("starv_inflight", 2'b10);
    bus_nw = 1'b0;
    step("starv_c6", 2'b10);
    step("starv_bubble", 2'b00);
    step("starv_m0", 2'b01);
    set_m0(0, 0, 0, 24'h000400, 16'h0000);
    step("starv_c9", 2'b00);
    set_m1(0, 0, 0, 24'h300000, 16'h0F0F);
    step("starv_c10", 2'b10);
    step("starv_c11", 2'b00);

    // Abandon: M0 drops re while stalled, unlocked.
    do_reset();
    set_m0(1, 0, 0, 24'h000500, 16'h0000);
    bus_nw = 1'b1;
    step("abandon_c0", 2'b00);
    step("abandon_c1", 2'b01);
    set_m0(0, 0, 0, 24'h000500, 16'h0000);
    step("abandon_c2", 2'b01);
    step("abandon_c3", 2'b00);

    // Asynchronous reset mid-transfer.
    set_m0(1, 0, 0, 24'h000600, 16'h0000);
    step("rst_c0", 2'b00);
    step("rst_c1", 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    mon_a = sample();
    checks++;
    if (mon_a !== model(2'b00)) begin
      errors++;
      $display("FAIL rst_async: got %h expected %h", mon_a, model(2'b00));
    end
    @(posedge clk);
    #1;
    do_reset();
    step("post_reset", 2'b00);

    #20;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
